byte_packing: RTL and testbench

Write-side counterpart of the byte-addressing loader: accepts the compressor's serial byte stream and packs it MSB-first into 32-bit words for the output FIFO. It sits between the LZ4/Huffman encoder output and the 32-bit output FIFO. It handles FIFO back-pressure with a one-word pending register and zero-pads the final partial word on end-of-stream. It reports the pad count and the number of words written.

---
 rtl/lz4_pkg.sv | 24 ++
 rtl/byte_pack_skid.sv | 43 ++++
 rtl/byte_packing.sv | 96 +++++++++
 tb/tb_byte_packing.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lz4_pkg.sv
// Shared widths and the packer state encoding for the LZ4/Huffman output path.
package lz4_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pack_state_t;

    // Place byte b into lane `lane` of word, MSB-first (lane 0 = [31:24]).
    function automatic logic [WORD_W-1:0] lane_insert(input logic [WORD_W-1:0] word,
                                                      input logic [1:0]        lane,
                                                      input logic [BYTE_W-1:0] b);
        logic [WORD_W-1:0] r;
        r = word;
        r[(WORD_W - 1 - BYTE_W * int'(lane)) -: BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/byte_pack_skid.sv
// One-word pending register between the byte accumulator and the output FIFO.
module byte_pack_skid
    import lz4_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic              load_last,
    input  logic [1:0]        load_pad,
    input  logic              fifo_full,
    output logic              pend_valid,
    output logic [WORD_W-1:0] pend_word,
    output logic              pend_last,
    output logic [1:0]        pend_pad,
    output logic              wr_en
);

    // Handshake: a word transfers to the FIFO in any cycle where pend_valid is
    // high and fifo_full is low (wr_en). The producer may assert load only when
    // pend is empty or is transferring in that same cycle; a same-cycle load wins.
    assign wr_en = pend_valid && !fifo_full && !clr;

    always_ff @(posedge clk) begin
        if (clr) begin
            pend_valid <= 1'b0;
            pend_word  <= '0;
            pend_last  <= 1'b0;
            pend_pad   <= 2'd0;
        end else if (load) begin
            pend_valid <= 1'b1;
            pend_word  <= load_word;
            pend_last  <= load_last;
            pend_pad   <= load_pad;
        end else if (wr_en) begin
            pend_valid <= 1'b0;
            pend_word  <= '0;
            pend_last  <= 1'b0;
            pend_pad   <= 2'd0;
        end
    end

endmodule

// File: rtl/byte_packing.sv
// Packs the encoder byte stream MSB-first into 32-bit FIFO words, zero-padding
// the final partial word and reporting pad count and words written.
module byte_packing
    import lz4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pack_en,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    input  logic              fifo_full,
    output logic              wr_fifo_en,
    output logic [WORD_W-1:0] fifo_wdata,
    output logic [1:0]        last_pad,
    output logic [WORD_W-1:0] word_cnt,
    output logic              pack_done
);

    pack_state_t       state, state_nxt;
    logic [WORD_W-1:0] acc;
    logic [1:0]        acc_cnt;
    logic              clr;
    logic              accept;
    logic              complete;
    logic [WORD_W-1:0] new_word;
    logic              pend_valid;
    logic              pend_last;
    logic [1:0]        pend_pad;

    assign clr      = rst || !pack_en;
    assign accept   = byte_valid && byte_ready;
    assign complete = accept && (acc_cnt == 2'd3 || byte_last);
    assign new_word = lane_insert(acc, acc_cnt, byte_in);

    // Any completing byte (lane 3 or byte_last) needs pend free or draining now.
    assign byte_ready = pack_en && (state == ST_FILL) &&
                        (!pend_valid || !fifo_full || (acc_cnt != 2'd3 && !byte_last));

    assign last_pad  = pend_last ? pend_pad : 2'd0;
    assign pack_done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = ST_FILL;
            ST_FILL:  if (accept && byte_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (wr_fifo_en && pend_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_FILL;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr || complete) begin
            acc     <= '0;
            acc_cnt <= 2'd0;
        end else if (accept) begin
            acc     <= new_word;
            acc_cnt <= acc_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            word_cnt <= '0;
        end else if (wr_fifo_en) begin
            word_cnt <= word_cnt + 32'd1;
        end
    end

    byte_pack_skid u_skid (
        .clk        (clk),
        .clr        (clr),
        .load       (complete),
        .load_word  (new_word),
        .load_last  (byte_last),
        .load_pad   (2'd3 - acc_cnt),
        .fifo_full  (fifo_full),
        .pend_valid (pend_valid),
        .pend_word  (fifo_wdata),
        .pend_last  (pend_last),
        .pend_pad   (pend_pad),
        .wr_en      (wr_fifo_en)
    );

endmodule

// File: tb/tb_byte_packing.sv
// Directed bench for byte_packing: expected FIFO words, pads and done pulses
// are hand-computed and held in a scoreboard queue.
module tb_byte_packing;

  logic        clk;
  logic        rst;
  logic        pack_en;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic        fifo_full;
  logic        wr_fifo_en;
  logic [31:0] fifo_wdata;
  logic [1:0]  last_pad;
  logic [31:0] word_cnt;
  logic        pack_done;

  byte_packing dut (
    .clk        (clk),
    .rst        (rst),
    .pack_en    (pack_en),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .fifo_full  (fifo_full),
    .wr_fifo_en (wr_fifo_en),
    .fifo_wdata (fifo_wdata),
    .last_pad   (last_pad),
    .word_cnt   (word_cnt),
    .pack_done  (pack_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;
  bit want_done = 0;
  bit rand_ff = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  exp_pad_q[$];
  bit          exp_last_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] w, input logic [1:0] pad, input bit last);
    exp_q.push_back(w);
    exp_pad_q.push_back(pad);
    exp_last_q.push_back(last);
  endtask

  // driver: called at posedge+1, returns at posedge+1 after the byte is accepted
  task automatic send_byte(input logic [7:0] b, input logic last);
    int guard;
    guard = 0;
    byte_in = b;
    byte_last = last;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("ready_wait", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_last = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int guard;
    guard = 0;
    while (done_cnt == start && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("done_wait", done_cnt, start + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // random back-pressure source
  always @(posedge clk) begin
    if (rand_ff) begin
      #1;
      fifo_full = ($urandom_range(0, 3) == 0);
    end
  end

  // scoreboard / monitor
  always @(negedge clk) begin
    if (want_done) begin
      check_eq("done_pulse", {31'd0, pack_done}, 32'd1);
      want_done = 0;
    end else if (pack_done) begin
      check_eq("done_spurious", {31'd0, pack_done}, 32'd0);
    end
    if (pack_done) done_cnt++;
    if (wr_fifo_en) begin
      if (exp_q.size() == 0) begin
        check_eq("unexp_write", {31'd0, wr_fifo_en}, 32'd0);
      end else begin
        logic [31:0] e;
        logic [1:0]  p;
        bit          l;
        e = exp_q.pop_front();
        p = exp_pad_q.pop_front();
        l = exp_last_q.pop_front();
        check_eq("wdata", fifo_wdata, e);
        check_eq("last_pad", {30'd0, last_pad}, {30'd0, p});
        if (l) want_done = 1;
      end
    end
  end

  logic [7:0]  bp [12];
  logic [7:0]  rb [1000];
  logic [31:0] w;
  int          idx;
  int          start;
  logic        acc_now;

  initial begin
    rst = 1'b1;
    pack_en = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    byte_last = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, byte_ready}, 32'd0);
    check_eq("rst_wr", {31'd0, wr_fifo_en}, 32'd0);
    check_eq("rst_wdata", fifo_wdata, 32'd0);
    check_eq("rst_pad", {30'd0, last_pad}, 32'd0);
    check_eq("rst_cnt", word_cnt, 32'd0);
    check_eq("rst_done", {31'd0, pack_done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pack_en = 1'b1;
    @(negedge clk);
    check_eq("ready_lag", {31'd0, byte_ready}, 32'd0);
    @(negedge clk);
    check_eq("ready_up", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 8-byte stream, two full words
    start = done_cnt;
    push_exp(32'h11121314, 2'd0, 0);
    push_exp(32'h15161718, 2'd0, 1);
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b0);
    @(negedge clk);
    check_eq("lat_n1", {31'd0, wr_fifo_en}, 32'd1);
    @(posedge clk);
    #1;
    for (int i = 4; i < 8; i++) send_byte(8'h11 + 8'(i), i == 7);
    wait_done(start);
    check_eq("cnt_after_8", word_cnt, 32'd2);

    // partial words
    start = done_cnt;
    push_exp(32'hAABBCC00, 2'd1, 1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    wait_done(start);
    start = done_cnt;
    push_exp(32'h5A000000, 2'd3, 1);
    send_byte(8'h5A, 1'b1);
    wait_done(start);
    check_eq("cnt_after_part", word_cnt, 32'd4);

    // back-pressure from the start of a stream
    for (int i = 0; i < 12; i++) bp[i] = 8'(i + 1);
    push_exp(32'h01020304, 2'd0, 0);
    push_exp(32'h05060708, 2'd0, 0);
    push_exp(32'h090A0B0C, 2'd0, 1);
    start = done_cnt;
    fifo_full = 1'b1;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      byte_in = bp[idx];
      byte_last = (idx == 11);
      byte_valid = 1'b1;
      @(negedge clk);
      acc_now = byte_ready;
      @(posedge clk);
      #1;
      if (acc_now) idx++;
    end
    byte_valid = 1'b0;
    byte_last = 1'b0;
    check_eq("bp_accepts", idx, 32'd7);
    @(negedge clk);
    check_eq("bp_ready_low", {31'd0, byte_ready}, 32'd0);
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    for (int i = 7; i < 12; i++) send_byte(bp[i], i == 11);
    wait_done(start);
    check_eq("cnt_after_bp", word_cnt, 32'd7);

    // disable clears word_cnt; then 1000 random bytes with gaps and back-pressure
    pack_en = 1'b0;
    idle_cycles(1);
    @(negedge clk);
    check_eq("dis_cnt", word_cnt, 32'd0);
    @(posedge clk);
    #1;
    pack_en = 1'b1;
    w = 32'd0;
    for (int i = 0; i < 1000; i++) begin
      rb[i] = 8'($urandom_range(0, 255));
      w = {w[23:0], rb[i]};
      if (i % 4 == 3) push_exp(w, 2'd0, i == 999);
    end
    start = done_cnt;
    rand_ff = 1;
    for (int i = 0; i < 1000; i++) begin
      idle_cycles($urandom_range(0, 2));
      send_byte(rb[i], i == 999);
    end
    rand_ff = 0;
    @(posedge clk);
    #2;
    fifo_full = 1'b0;
    wait_done(start);
    check_eq("rand_cnt", word_cnt, 32'd250);
    check_eq("rand_q_empty", exp_q.size(), 32'd0);

    // pack_en drop with pend full and two bytes in the accumulator
    fifo_full = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'h31 + 8'(i), 1'b0);
    pack_en = 1'b0;
    @(negedge clk);
    check_eq("drop_ready", {31'd0, byte_ready}, 32'd0);
    check_eq("drop_wr", {31'd0, wr_fifo_en}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("drop_wdata", fifo_wdata, 32'd0);
    check_eq("drop_pad", {30'd0, last_pad}, 32'd0);
    check_eq("drop_cnt", word_cnt, 32'd0);
    check_eq("drop_done", {31'd0, pack_done}, 32'd0);
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    idle_cycles(3);
    pack_en = 1'b1;
    start = done_cnt;
    push_exp(32'hC1C2C3C4, 2'd0, 1);
    for (int i = 0; i < 4; i++) send_byte(8'hC1 + 8'(i), i == 3);
    wait_done(start);
    check_eq("reen_cnt", word_cnt, 32'd1);

    // reset while in DRAIN
    fifo_full = 1'b1;
    send_byte(8'h77, 1'b1);
    @(negedge clk);
    check_eq("drain_ready", {31'd0, byte_ready}, 32'd0);
    check_eq("drain_wr", {31'd0, wr_fifo_en}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rstd_done", {31'd0, pack_done}, 32'd0);
    check_eq("rstd_wr", {31'd0, wr_fifo_en}, 32'd0);
    check_eq("rstd_cnt", word_cnt, 32'd0);
    check_eq("rstd_ready", {31'd0, byte_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fifo_full = 1'b0;
    idle_cycles(5);

    check_eq("final_q_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
